key_debounce4: RTL
==================

Name: key_debounce4

Overview:
- Upstream conditioning stage for the lab1 display path.
- Takes four raw, bouncing, asynchronous push-button/switch inputs and synchronises and debounces each one.
- Produces clean per-key levels plus one-cycle press/release pulses. key_level drives the 4-to-2 priority encoder input directly.
- All keys are independent; the debounce time is parameterised.

Parameters:
- N_KEYS, 4, number of independent key channels.
- STABLE_CYCLES, 1000000, consecutive synchronised cycles a new value must hold before acceptance (10 ms at 100 MHz). Must be >= 2.
- CNT_WIDTH, 20, debounce counter width. Must satisfy 2**CNT_WIDTH >= STABLE_CYCLES.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- key_raw  in  N_KEYS  raw asynchronous key inputs, 1 = pressed.
- key_level  out  N_KEYS  debounced key state, 1 = pressed.
- key_press  out  N_KEYS  one-cycle pulse when key_level rises.
- key_release  out  N_KEYS  one-cycle pulse when key_level falls.
- any_held  out  1  OR-reduction of key_level, registered.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on port reset; it is sampled only on the rising clk edge.
- Reset values: all outputs 0, all synchroniser flops 0, all counters 0.
- Synchroniser: two-flop chain per key, key_raw -> s1 -> s2. A raw change first appears in s2 after 2 rising edges.
- Per-key state: level bit L plus counter C.
  - s2 == L: C is cleared to 0. Any glitch shorter than STABLE_CYCLES is therefore discarded.
  - s2 != L and C < STABLE_CYCLES-1: C increments.
  - s2 != L and C == STABLE_CYCLES-1: on the next edge L toggles and C clears.
- Latency: from the first edge at which key_raw is sampled at a new stable value to the key_level change is exactly STABLE_CYCLES+2 edges.
- Pulses:
  - key_press[i] = 1 in exactly the cycle L first reads 1 after a 0->1 toggle.
  - key_release[i] = 1 in exactly the cycle L first reads 0 after a 1->0 toggle.
  - Both pulses are registered, never combinational from key_raw. They are never high simultaneously on one key and never last more than one cycle.
- any_held: registered alongside key_level, so it tracks key_level with zero offset (same-cycle).
- Bounce: the counter restarts on every toggle, so a burst of toggles yields at most one level change. That change occurs STABLE_CYCLES+2 edges after the last raw transition settles.
- Simultaneous events: keys are fully independent. Multiple bits may change, and may pulse, in the same cycle.
- Key held through reset: reported as 0 during reset. After reset deasserts it is debounced from scratch, and key_press fires STABLE_CYCLES+2 edges later.
- Reset mid-count: the counter is discarded and no pulse is produced. Counting restarts after reset.
- Counter never exceeds STABLE_CYCLES-1, so no wrap-around is possible.

Decomposition:
- Shared package display_pkg holds:
  - KEY_N = 4
  - DEBOUNCE_CYCLES = 1000000
  - DEBOUNCE_CW = 20
- Sub-module debounce_cell: one key; synchroniser, counter, level and pulse registers. Instantiated N_KEYS times via generate.
- any_held is computed and registered at the top level.

Test Plan (STABLE_CYCLES=4, CNT_WIDTH=3):
1. Key held through reset: key_raw=4'b0001 held through reset for 3 cycles, then reset drops at edge 0 -> key_level=0 throughout reset; key_level=4'b0001 from edge 6; key_press=4'b0001 for exactly edge 6; any_held=1 from edge 6.
2. Short glitch: key_raw[1]=1 for 3 cycles, then 0 -> key_level, key_press and key_release stay 0 throughout.
3. Clean press and release: key_raw=4'b0100 held 20 cycles, then 0 ->
   - key_level=4'b0100 exactly 6 edges after the press, key_press one cycle;
   - key_level=0 exactly 6 edges after the release, key_release=4'b0100 one cycle.
4. Bounce: key_raw[3] toggles every 2 cycles for 10 cycles, then stays 1 -> exactly one key_press[3] pulse; key_level[3]=1 exactly 6 edges after the final 0->1.
5. Simultaneous press: key_raw goes 0 -> 4'b1001 in one cycle -> key_level=4'b1001 on the same edge; key_press=4'b1001 for one cycle; downstream encoder sees 4'b1001.
6. Reset mid-count: key_raw[2]=1, reset pulsed 1 cycle at count 2 -> no pulse; key_level[2] rises exactly 6 edges after reset deasserts.

Source files
------------

// File: rtl/display_pkg.sv
// display_pkg: shared sizing constants for the lab1 display path.
package display_pkg;
    localparam int KEY_N           = 4;
    localparam int DEBOUNCE_CYCLES = 1000000;
    localparam int DEBOUNCE_CW     = 20;
endpackage

// File: rtl/debounce_cell.sv
// debounce_cell: one key channel with two-flop synchroniser, stability counter, level and edge pulses.
module debounce_cell #(
    parameter int STABLE_CYCLES = 1000000,
    parameter int CNT_WIDTH     = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic key_raw,
    output logic level_nxt,
    output logic level,
    output logic press,
    output logic rel
);
    logic s1_q, s1_d, s2_q, s2_d, lvl_q, lvl_d, press_q, press_d, rel_q, rel_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic diff, done;
    always_comb begin
        s1_d    = key_raw;
        s2_d    = s1_q;
        diff    = s2_q != lvl_q;
        done    = diff && (cnt_q == CNT_WIDTH'(STABLE_CYCLES - 1));
        // any agreement between synchronised input and level restarts the count
        cnt_d   = (diff && !done) ? cnt_q + 1'b1 : '0;
        lvl_d   = lvl_q ^ done;
        press_d = done && !lvl_q;
        rel_d   = done && lvl_q;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            cnt_q   <= '0;
            lvl_q   <= 1'b0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            cnt_q   <= cnt_d;
            lvl_q   <= lvl_d;
            press_q <= press_d;
            rel_q   <= rel_d;
        end
    end
    assign level_nxt = lvl_d;
    assign level     = lvl_q;
    assign press     = press_q;
    assign rel       = rel_q;
endmodule

// File: rtl/key_debounce4.sv
// key_debounce4: debounces N_KEYS raw keys into clean levels, press/release pulses and a held flag.
module key_debounce4
    import display_pkg::*;
#(
    parameter int N_KEYS        = KEY_N,
    parameter int STABLE_CYCLES = DEBOUNCE_CYCLES,
    parameter int CNT_WIDTH     = DEBOUNCE_CW
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_KEYS-1:0] key_raw,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release,
    output logic              any_held
);
    logic [N_KEYS-1:0] level_d;
    logic any_held_d, any_held_q;
    for (genvar i = 0; i < N_KEYS; i++) begin : g_key
        debounce_cell #(.STABLE_CYCLES(STABLE_CYCLES), .CNT_WIDTH(CNT_WIDTH)) u_cell (
            .clk      (clk),
            .reset    (reset),
            .key_raw  (key_raw[i]),
            .level_nxt(level_d[i]),
            .level    (key_level[i]),
            .press    (key_press[i]),
            .rel      (key_release[i])
        );
    end
    // built from next-state levels so it lands on the same edge as key_level
    always_comb any_held_d = |level_d;
    always_ff @(posedge clk) begin
        if (reset) any_held_q <= 1'b0;
        else       any_held_q <= any_held_d;
    end
    assign any_held = any_held_q;
endmodule
